serial_adder: RTL

Bit-serial ripple adder that adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop. It is the additive counterpart of the half-subtractor difference/borrow cell. It provides a low-area sequential adder for the partial-product summation path of the vedic multiplier. A start/busy/done handshake lets a controller issue one addition at a time.

---
 rtl/serial_adder.sv | 74 +++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with one full-adder slice and a carry flop.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, ps, nps;
  logic [CW-1:0] cnt;
  logic c, s, cm;
  assign s   = sa[0] ^ sb[0] ^ c;
  assign cm  = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
  assign nps = {s, ps[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          c     <= cin;
          cnt   <= '0;
          ps    <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          c   <= cm;
          ps  <= nps;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= nps;
            cout  <= cm;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
